// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences one CPU memory transaction at a time between the MAR/MDR
//   datapath and a 512-word RAM. A read waits for the RAM ack, captures
//   the RAM data into mdatain and pulses the MDR load/read enables for one
//   cycle. A write presents the MDR contents at the MAR address until the
//   RAM acks. Every transaction ends with a one-cycle done pulse.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     Defined   : an ACCESS that sees no mem_ack for TIMEOUT cycles ends
//                 with done=1 and error=1. No MDR load happens.
//     Undefined : ACCESS waits forever and error is tied to 0.
//
// Ports
//   Clock        in   rising-edge system clock
//   Clear        in   synchronous active-high reset
//   start_read   in   read request strobe (wins over start_write)
//   start_write  in   write request strobe
//   mar_addr     in   address from MAR
//   mdr_q        in   MDR output, used as write data
//   busy         out  high whenever the controller is not idle
//   done         out  one-cycle completion pulse
//   error        out  high together with done on a timed-out access
//   mdr_load     out  MDR enable
//   mdr_read     out  MDR Read_from_mem select
//   mdatain      out  registered RAM read data for the MDR
//   mem_addr     out  RAM address
//   mem_wdata    out  RAM write data
//   mem_rd       out  RAM read request
//   mem_wr       out  RAM write request
//   mem_rdata    in   RAM read data, valid when mem_ack=1
//   mem_ack      in   RAM completion pulse
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              start_read,
  input  logic              start_write,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic [DATA_W-1:0] mdr_q,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mdr_load,
  output logic              mdr_read,
  output logic [DATA_W-1:0] mdatain,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_LOAD   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  logic   r_op_rd;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  // r_cnt holds the number of ACCESS cycles already finished without ack;
  // the cycle now ending is therefore the last allowed one when it reads
  // TIMEOUT-1.
  logic [CNT_W-1:0] r_cnt;
  logic             r_error;
  logic             w_timeout;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign error     = r_error;
`else
  assign error     = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state   <= S_IDLE;
      r_op_rd   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mdr_load  <= 1'b0;
      mdr_read  <= 1'b0;
      mdatain   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_cnt     <= '0;
      r_error   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_read || start_write) begin
            r_state   <= S_ACCESS;
            r_op_rd   <= start_read;
            mem_addr  <= mar_addr;
            mem_wdata <= mdr_q;
            busy      <= 1'b1;
            mem_rd    <= start_read;
            mem_wr    <= ~start_read;
`ifdef MEM_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end

        S_ACCESS: begin
          if (mem_ack) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            if (r_op_rd) begin
              mdatain  <= mem_rdata;
              mdr_load <= 1'b1;
              mdr_read <= 1'b1;
              r_state  <= S_LOAD;
            end else begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (w_timeout) begin
            // Abandon the access: skip LOAD so the MDR keeps its value.
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            done    <= 1'b1;
            r_error <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end

        S_LOAD: begin
          mdr_load <= 1'b0;
          mdr_read <= 1'b0;
          done     <= 1'b1;
          r_state  <= S_DONE;
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          r_error <= 1'b0;
`endif
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              Clock = 1'b0;
  logic              Clear;
  logic              start_read, start_write;
  logic [ADDR_W-1:0] mar_addr;
  logic [DATA_W-1:0] mdr_q;
  logic              busy, done, error, mdr_load, mdr_read;
  logic [DATA_W-1:0] mdatain, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_wr, mem_ack;

  always #5 Clock = ~Clock;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Clear(Clear),
    .start_read(start_read), .start_write(start_write),
    .mar_addr(mar_addr), .mdr_q(mdr_q),
    .busy(busy), .done(done), .error(error),
    .mdr_load(mdr_load), .mdr_read(mdr_read), .mdatain(mdatain),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Transaction-timeline model: remembers when the current transaction was
  // accepted and when it ended its ACCESS phase, and derives every output
  // from the distance (in edges) to those two points.
  int                e = 0;
  bit                m_valid = 1'b0;
  bit                m_act = 1'b0, m_rd = 1'b0, m_to = 1'b0;
  int                m_acc = 0, m_ack = -1;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0, m_mdatain = '0;

  function automatic int done_off();
    return (m_rd && !m_to) ? 1 : 0;
  endfunction

  always @(posedge Clock) begin
    e = e + 1;
    if (Clear) begin
      m_valid = 1'b1; m_act = 1'b0; m_to = 1'b0;
      m_addr = '0; m_wdata = '0; m_mdatain = '0;
    end else if (!m_act) begin
      if (start_read || start_write) begin
        m_act = 1'b1; m_rd = start_read; m_to = 1'b0;
        m_addr = mar_addr; m_wdata = mdr_q; m_acc = e; m_ack = -1;
      end
    end else if (m_ack < 0) begin
      if (mem_ack) begin
        m_ack = e;
        if (m_rd) m_mdatain = mem_rdata;
      end
`ifdef MEM_TIMEOUT_EN
      else if (e - m_acc == TIMEOUT) begin
        m_ack = e; m_to = 1'b1;
      end
`endif
    end else if (e - m_ack > done_off()) begin
      m_act = 1'b0;
    end
  end

  int nvec = 0, nerr = 0;
  int cnt_rd = 0, cnt_wr = 0, cnt_ld = 0, cnt_done = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    bit in_acc, post, x_ld, x_done;
    int k;
    if (!m_valid) return;
    in_acc = m_act && (m_ack < 0);
    post   = m_act && (m_ack >= 0);
    k      = e - m_ack;
    x_ld   = post && m_rd && !m_to && (k == 0);
    x_done = post && (k == done_off());
    check("busy",      32'(busy),      32'(m_act));
    check("mem_rd",    32'(mem_rd),    32'(in_acc && m_rd));
    check("mem_wr",    32'(mem_wr),    32'(in_acc && !m_rd));
    check("mdr_load",  32'(mdr_load),  32'(x_ld));
    check("mdr_read",  32'(mdr_read),  32'(x_ld));
    check("done",      32'(done),      32'(x_done));
    check("error",     32'(error),     32'(x_done && m_to));
    check("mem_addr",  32'(mem_addr),  32'(m_addr));
    check("mem_wdata", mem_wdata,      m_wdata);
    check("mdatain",   mdatain,        m_mdatain);
    cnt_rd   += int'(mem_rd);
    cnt_wr   += int'(mem_wr);
    cnt_ld   += int'(mdr_load);
    cnt_done += int'(done);
  endtask

  // One clock cycle: model compare mid-cycle, then land just after the edge.
  task automatic tick();
    @(negedge Clock);
    cmp_cycle();
    @(posedge Clock);
    #1;
  endtask

  int s_rd, s_wr, s_ld, s_done;
  task automatic snap();
    s_rd = cnt_rd; s_wr = cnt_wr; s_ld = cnt_ld; s_done = cnt_done;
  endtask

  initial begin
    Clear = 1'b1; start_read = 1'b0; start_write = 1'b0;
    mar_addr = '0; mdr_q = '0; mem_rdata = '0; mem_ack = 1'b0;

    // Clear for two cycles, then idle
    tick(); tick();
    Clear = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mdatain", mdatain, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Start while Clear is high is dropped
    Clear = 1'b1; start_read = 1'b1; mar_addr = 9'h055;
    tick();
    Clear = 1'b0; start_read = 1'b0;
    tick();
    check("clr_start_busy", 32'(busy), 32'd0);
    check("clr_start_addr", 32'(mem_addr), 32'd0);

    // Read, ack in the third ACCESS cycle
    snap();
    mar_addr = 9'h0A5; start_read = 1'b1;
    tick();
    start_read = 1'b0; mar_addr = '0;
    tick(); tick();
    check("rd_addr", 32'(mem_addr), 32'h0A5);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    check("rd_mdatain", mdatain, 32'hDEADBEEF);
    check("rd_load", 32'(mdr_load && mdr_read), 32'd1);
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    check("rd_done", 32'(done), 32'd1);
    check("rd_error", 32'(error), 32'd0);
    tick(); tick();
    check("rd_cycles", 32'(cnt_rd - s_rd), 32'd3);
    check("rd_loads", 32'(cnt_ld - s_ld), 32'd1);
    check("rd_dones", 32'(cnt_done - s_done), 32'd1);

    // Write, immediate ack
    snap();
    mar_addr = 9'h1FF; mdr_q = 32'h12345678; start_write = 1'b1;
    tick();
    start_write = 1'b0; mem_ack = 1'b1;
    check("wr_wr", 32'(mem_wr), 32'd1);
    check("wr_wdata", mem_wdata, 32'h12345678);
    check("wr_addr", 32'(mem_addr), 32'h1FF);
    tick();
    mem_ack = 1'b0;
    check("wr_done", 32'(done), 32'd1);
    tick(); tick();
    check("wr_cycles", 32'(cnt_wr - s_wr), 32'd1);
    check("wr_loads", 32'(cnt_ld - s_ld), 32'd0);
    check("wr_mdatain_kept", mdatain, 32'hDEADBEEF);

    // Simultaneous strobes: read wins; a write during busy is ignored
    snap();
    mar_addr = 9'h033; start_read = 1'b1; start_write = 1'b1;
    tick();
    start_read = 1'b0; start_write = 1'b0;
    check("col_rd", 32'(mem_rd), 32'd1);
    check("col_wr", 32'(mem_wr), 32'd0);
    mar_addr = 9'h0EE; mdr_q = 32'hCAFEF00D; start_write = 1'b1;
    tick();
    start_write = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick(); tick();
    check("col_addr", 32'(mem_addr), 32'h033);
    check("col_mdatain", mdatain, 32'h0BADF00D);
    check("col_no_wr", 32'(cnt_wr - s_wr), 32'd0);

    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_mdatain", mdatain, 32'h0BADF00D);

    // Clear in the second ACCESS cycle of a read
    snap();
    mar_addr = 9'h111; start_read = 1'b1;
    tick();
    start_read = 1'b0;
    tick();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd", 32'(mem_rd), 32'd0);
    check("abort_mdatain", mdatain, 32'd0);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h13579BDF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("abort_no_done", 32'(cnt_done - s_done), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // No ack: timeout after 15 ACCESS cycles
    snap();
    mar_addr = 9'h0C3; start_read = 1'b1;
    tick();
    start_read = 1'b0;
    repeat (TIMEOUT) tick();
    check("to_done", 32'(done), 32'd1);
    check("to_error", 32'(error), 32'd1);
    tick(); tick();
    check("to_rd_cycles", 32'(cnt_rd - s_rd), 32'd15);
    check("to_loads", 32'(cnt_ld - s_ld), 32'd0);

    // Ack in the 15th ACCESS cycle is a success
    start_read = 1'b1;
    tick();
    start_read = 1'b0;
    repeat (TIMEOUT - 1) tick();
    mem_ack = 1'b1; mem_rdata = 32'h600DCAFE;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("late_load", 32'(mdr_load), 32'd1);
    tick();
    check("late_done", 32'(done), 32'd1);
    check("late_error", 32'(error), 32'd0);
    tick(); tick();
    check("late_mdatain", mdatain, 32'h600DCAFE);
`else
    // No ack and no timeout: stays busy
    mar_addr = 9'h0C3; start_read = 1'b1;
    tick();
    start_read = 1'b0;
    repeat (100) tick();
    check("hang_busy", 32'(busy), 32'd1);
    check("hang_rd", 32'(mem_rd), 32'd1);
    check("hang_error", 32'(error), 32'd0);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    tick(); tick();
    check("hang_cleared", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
